// File: rtl/serial_fadd_ctrl.sv
// -----------------------------------------------------------------------------
// serial_fadd_ctrl
//
// Bit-serial adder controller. A single 1-bit full adder is time-multiplexed
// across NBITS-bit operands, one bit per cycle, LSB first. An operation is
// accepted through a val/rdy handshake, computed over NBITS cycles, and the
// result is presented through a second val/rdy handshake.
//
// Ports:
//   clk       rising-edge clock
//   reset     synchronous, active-low reset
//   in_val    requester has a valid operation
//   in_rdy    block can accept an operation (high only in IDLE)
//   in_a      operand A, sampled on the input-transfer edge
//   in_b      operand B, sampled on the input-transfer edge
//   in_cin    carry-in, sampled on the input-transfer edge
//   out_val   result valid (high only in DONE)
//   out_rdy   consumer accepts the result
//   out_sum   (in_a + in_b + in_cin) mod 2^NBITS
//   out_cout  carry-out of the NBITS-bit add
// -----------------------------------------------------------------------------
module serial_fadd_ctrl #(
    parameter int NBITS = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_val,
    output logic             in_rdy,
    input  logic [NBITS-1:0] in_a,
    input  logic [NBITS-1:0] in_b,
    input  logic             in_cin,
    output logic             out_val,
    input  logic             out_rdy,
    output logic [NBITS-1:0] out_sum,
    output logic             out_cout
);

    // Counter only has to reach NBITS-1; keep at least one bit for NBITS==1.
    localparam int CW = (NBITS > 1) ? $clog2(NBITS) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(NBITS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic             load;
    logic             shift;
    logic [NBITS-1:0] a_reg;
    logic [NBITS-1:0] b_reg;
    logic [NBITS-1:0] sum_reg;
    logic [NBITS-1:0] sum_shifted;
    logic             carry;
    logic [CW-1:0]    count;
    logic             fa_sum;
    logic             fa_cout;

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state and handshake decode. Handshake outputs depend on state only.
    // -------------------------------------------------------------------------
    // NOTE: every output of this block gets a default first, so no path
    // through the case leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        in_rdy     = 1'b0;
        out_val    = 1'b0;
        load       = 1'b0;
        shift      = 1'b0;
        case (state)
            IDLE: begin
                in_rdy = 1'b1;
                if (in_val) begin
                    load       = 1'b1;
                    state_next = CALC;
                end
            end
            CALC: begin
                shift = 1'b1;
                if (count == LAST_BIT) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                out_val = 1'b1;
                if (out_rdy) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // The shared full adder works on the current LSBs and the carry flop.
    // -------------------------------------------------------------------------
    assign fa_sum  = a_reg[0] ^ b_reg[0] ^ carry;
    assign fa_cout = (a_reg[0] & b_reg[0]) | (carry & (a_reg[0] ^ b_reg[0]));

    // New sum bit enters at the MSB; after NBITS shifts the first (LSB) result
    // bit has walked down to bit 0. Written as shift-then-overwrite so it
    // stays legal for NBITS==1.
    always_comb begin
        sum_shifted            = sum_reg >> 1;
        sum_shifted[NBITS-1]   = fa_sum;
    end

    // -------------------------------------------------------------------------
    // Datapath registers
    // -------------------------------------------------------------------------
    // NOTE: operand registers are reset as well; they are few flops and this
    // keeps simulation free of X on the adder inputs before the first load.
    always_ff @(posedge clk) begin
        if (!reset) begin
            a_reg   <= '0;
            b_reg   <= '0;
            sum_reg <= '0;
            carry   <= 1'b0;
            count   <= '0;
        end else if (load) begin
            a_reg <= in_a;
            b_reg <= in_b;
            carry <= in_cin;
            count <= '0;
        end else if (shift) begin
            a_reg   <= a_reg >> 1;
            b_reg   <= b_reg >> 1;
            sum_reg <= sum_shifted;
            carry   <= fa_cout;
            count   <= count + 1'b1;
        end
    end

    assign out_sum  = sum_reg;
    assign out_cout = carry;

endmodule
